// File: rtl/trainer_pkg.sv
// rtl/trainer_pkg.sv - shared types, constants and gate evaluation for the gate trainer
package trainer_pkg;

    localparam int SIG_W = 16;

    typedef enum logic [2:0] {
        GATE_AND  = 3'd0,
        GATE_OR   = 3'd1,
        GATE_NAND = 3'd2,
        GATE_NOR  = 3'd3,
        GATE_XOR  = 3'd4,
        GATE_XNOR = 3'd5,
        GATE_NOTA = 3'd6,
        GATE_RSVD = 3'd7
    } gate_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    // Single-bit evaluation; callers apply it per bit to stay width-agnostic.
    function automatic logic gate_eval(input logic a, input logic b, input logic [2:0] sel);
        case (sel)
            GATE_AND:  return a & b;
            GATE_OR:   return a | b;
            GATE_NAND: return ~(a & b);
            GATE_NOR:  return ~(a | b);
            GATE_XOR:  return a ^ b;
            GATE_XNOR: return ~(a ^ b);
            GATE_NOTA: return ~a;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/trainer_gate_alu.sv
// rtl/trainer_gate_alu.sv - combinational bitwise gate evaluator
module trainer_gate_alu
    import trainer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        for (int i = 0; i < WIDTH; i++) begin
            y[i] = gate_eval(a[i], b[i], sel);
        end
    end

endmodule

// File: rtl/trainer_gate_sequencer.sv
// rtl/trainer_gate_sequencer.sv - manual gate evaluation and paced exhaustive operand sweep
module trainer_gate_sequencer
    import trainer_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int STEP_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             start,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature
);

    localparam int PACE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PACE_W-1:0] PACE_LAST = PACE_W'(STEP_DIV - 1);
    localparam logic [WIDTH-1:0]  CNT_MAX   = '1;

    state_e            state, state_nxt;
    logic [2:0]        sel_q;
    logic [WIDTH-1:0]  cnt_a, cnt_b;
    logic [PACE_W-1:0] pace;
    logic [WIDTH-1:0]  alu_a, alu_b, alu_y;
    logic [2:0]        alu_sel;
    logic              handshake, pace_end, last_vec, idle;

    assign idle      = (state == IDLE);
    assign handshake = out_valid & out_ready;
    assign pace_end  = (pace == PACE_LAST);
    assign last_vec  = (cnt_a == CNT_MAX) && (cnt_b == CNT_MAX);

    // Live switches drive the evaluator only while idle; a sweep uses its own counters and gate.
    assign alu_a   = idle ? a_in : cnt_a;
    assign alu_b   = idle ? b_in : cnt_b;
    assign alu_sel = idle ? sel  : sel_q;

    trainer_gate_alu #(.WIDTH(WIDTH)) u_alu (
        .a   (alu_a),
        .b   (alu_b),
        .sel (alu_sel),
        .y   (alu_y)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (mode && start) state_nxt = RUN;
            RUN:  if (pace_end) state_nxt = WAIT;
            WAIT: if (handshake) state_nxt = last_vec ? DONE : RUN;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN, WAIT: busy = 1'b1;
            DONE:      done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y         <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_valid <= 1'b0;
            signature <= '0;
            sel_q     <= '0;
            cnt_a     <= '0;
            cnt_b     <= '0;
            pace      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!mode) begin
                        y <= alu_y;
                    end else if (start) begin
                        sel_q     <= sel;
                        cnt_a     <= '0;
                        cnt_b     <= '0;
                        pace      <= '0;
                        signature <= '0;
                    end
                end
                RUN: begin
                    if (pace_end) begin
                        out_a     <= cnt_a;
                        out_b     <= cnt_b;
                        y         <= alu_y;
                        out_valid <= 1'b1;
                    end else begin
                        pace <= pace + 1'b1;
                    end
                end
                WAIT: begin
                    if (handshake) begin
                        signature <= {signature[SIG_W-2:0], signature[SIG_W-1]}
                                     ^ {{(SIG_W-WIDTH){1'b0}}, y};
                        out_valid <= 1'b0;
                        pace      <= '0;
                        cnt_b     <= cnt_b + 1'b1;
                        if (cnt_b == CNT_MAX) cnt_a <= cnt_a + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
